// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output serializer.
// bitrev() is only referenced when FFT_SER_BITREV_EN is defined.
package fft_pkg;

    localparam int FFT_N_PT = 32;
    localparam int FFT_DW   = 16;
    localparam int FFT_IW   = 5;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Reverse the low 'width' bits of idx; upper bits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[width-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ser_ctrl.sv
// Serializer control: IDLE/SHIFT state, beat counter and handshake generation.
module fft_ser_ctrl
    import fft_pkg::*;
#(
    parameter int N_PT = FFT_N_PT,
    parameter int IW   = $clog2(N_PT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_last,
    output logic          load,
    output logic [IW-1:0] cnt
);

    localparam logic [IW-1:0] CNT_LAST = IW'(N_PT - 1);

    ser_state_t    state_r, state_nxt_s;
    logic [IW-1:0] cnt_r, cnt_nxt_s;
    logic          last_s;

    // State and beat counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and handshake logic; a last-beat accept may reload in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        last_s      = 1'b0;
        load        = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    load        = 1'b1;
                    cnt_nxt_s   = {IW{1'b0}};
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                last_s    = (cnt_r == CNT_LAST);
                in_ready  = !rst && out_ready && last_s;
                if (out_ready) begin
                    if (last_s) begin
                        cnt_nxt_s = {IW{1'b0}};
                        if (in_valid && !rst) begin
                            load        = 1'b1;
                            state_nxt_s = SHIFT;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + IW'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {IW{1'b0}};
            end
        endcase
    end

    assign out_last = last_s;
    assign cnt      = cnt_r;

endmodule

// File: rtl/fft_frame_serializer.sv
// Captures one parallel complex FFT frame and streams it out one sample per beat.
// Optional macro FFT_SER_BITREV_EN emits lanes in bit-reversed order.
module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int N_PT = FFT_N_PT,
    parameter int DW   = FFT_DW,
    parameter int IW   = $clog2(N_PT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_PT*DW-1:0]     in_r,
    input  logic [N_PT*DW-1:0]     in_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DW-1:0]   out_r,
    output logic signed [DW-1:0]   out_i,
    output logic [IW-1:0]          out_idx,
    output logic                   out_last
);

    logic signed [DW-1:0] re_r [N_PT];
    logic signed [DW-1:0] im_r [N_PT];
    logic                 load_s;
    logic [IW-1:0]        cnt_s;
    logic [IW-1:0]        sel_s;

    fft_ser_ctrl #(
        .N_PT (N_PT),
        .IW   (IW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .load      (load_s),
        .cnt       (cnt_s)
    );

    // Frame registers: cleared on reset, loaded whole on an accepted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_PT; k++) begin
                re_r[k] <= {DW{1'b0}};
                im_r[k] <= {DW{1'b0}};
            end
        end else if (load_s) begin
            for (int k = 0; k < N_PT; k++) begin
                re_r[k] <= in_r[k*DW +: DW];
                im_r[k] <= in_i[k*DW +: DW];
            end
        end
    end

`ifdef FFT_SER_BITREV_EN
    assign sel_s = IW'(bitrev(32'(cnt_s), IW));
`else
    assign sel_s = cnt_s;
`endif

    // Outputs select purely from registered state, so stalls hold them stable.
    assign out_r   = re_r[sel_s];
    assign out_i   = im_r[sel_s];
    assign out_idx = sel_s;

endmodule
